// File: rtl/fetch_pkg.sv
// Shared IF-stage definitions: state encoding, instruction constants, word width.
// Decode reuses XLEN and word_t from here.
package fetch_pkg;

    localparam int XLEN = 16;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        S_FETCH  = 2'b00,
        S_MISS   = 2'b01,
        S_HALTED = 2'b10
    } fetch_state_t;

    typedef enum logic {
        PC_SEL_INC   = 1'b0,
        PC_SEL_REDIR = 1'b1
    } pc_sel_t;

    localparam word_t      NOP_INSTR_C  = 16'h0000;
    localparam logic [3:0] HLT_OPCODE_C = 4'hF;

endpackage

// File: rtl/fetch_ctrl_fsm.sv
// Fetch control: next-state and register-enable decode for the IF stage.
// Priority is redirect, then stall, then the memory response.
module fetch_ctrl_fsm
    import fetch_pkg::*;
(
    input  fetch_state_t i_state,
    input  logic         i_stall,
    input  logic         i_redirect,
    input  logic         i_imem_rdy,
    input  logic         i_hlt_detect,
    output fetch_state_t o_next,
    output logic         o_pc_we,
    output pc_sel_t      o_pc_sel,
    output logic         o_ifid_we,
    output logic         o_ifid_bubble
);

    always_comb begin
        o_next = i_state;
        if (i_redirect) begin
            o_next = S_FETCH;
        end else if (i_stall) begin
            o_next = i_state;
        end else if (i_state == S_HALTED) begin
            o_next = S_HALTED;
        end else if (!i_imem_rdy) begin
            o_next = S_MISS;
        end else if (i_hlt_detect) begin
            o_next = S_HALTED;
        end else begin
            o_next = S_FETCH;
        end
    end

    always_comb begin
        o_pc_we       = 1'b0;
        o_pc_sel      = PC_SEL_INC;
        o_ifid_we     = 1'b0;
        o_ifid_bubble = 1'b0;
        if (i_redirect) begin
            o_pc_we       = 1'b1;
            o_pc_sel      = PC_SEL_REDIR;
            o_ifid_we     = 1'b1;
            o_ifid_bubble = 1'b1;
        end else if (i_stall) begin
            o_pc_we = 1'b0;
        end else if (i_state == S_HALTED || !i_imem_rdy) begin
            o_ifid_we     = 1'b1;
            o_ifid_bubble = 1'b1;
        end else begin
            // HLT is latched but the PC parks on its own address
            o_pc_we   = !i_hlt_detect;
            o_ifid_we = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, instruction-memory request, I-cache miss tolerance, IF/ID latch.
// Fetch stops on HLT and resumes only on redirect or reset.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = NOP_INSTR_C,
    parameter logic [3:0]  HLT_OPCODE = HLT_OPCODE_C
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc2,
    output logic        if_id_valid,
    output logic        halted
);

    fetch_state_t r_state;
    word_t        r_pc;
    word_t        r_instr;
    word_t        r_pc2;
    logic         r_valid;

    fetch_state_t w_next;
    logic         w_pc_we;
    pc_sel_t      w_pc_sel;
    logic         w_ifid_we;
    logic         w_ifid_bubble;
    logic         w_hlt;
    word_t        w_pc_inc;

    assign w_hlt    = (imem_data[15:12] == HLT_OPCODE);
    assign w_pc_inc = r_pc + XLEN'(2);

    fetch_ctrl_fsm u_ctrl (
        .i_state       (r_state),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_imem_rdy    (imem_rdy),
        .i_hlt_detect  (w_hlt),
        .o_next        (w_next),
        .o_pc_we       (w_pc_we),
        .o_pc_sel      (w_pc_sel),
        .o_ifid_we     (w_ifid_we),
        .o_ifid_bubble (w_ifid_bubble)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (w_pc_we) begin
            r_pc <= (w_pc_sel == PC_SEL_REDIR) ? redirect_pc : w_pc_inc;
        end
    end

    // Miss/halt bubbles keep pc2; only a flush clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr <= NOP_INSTR;
            r_pc2   <= '0;
            r_valid <= 1'b0;
        end else if (w_ifid_we) begin
            if (w_ifid_bubble) begin
                r_instr <= NOP_INSTR;
                r_pc2   <= redirect ? '0 : r_pc2;
                r_valid <= 1'b0;
            end else begin
                r_instr <= imem_data;
                r_pc2   <= w_pc_inc;
                r_valid <= 1'b1;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign imem_req    = (r_state != S_HALTED);
    assign halted      = (r_state == S_HALTED);
    assign if_id_instr = r_instr;
    assign if_id_pc2   = r_pc2;
    assign if_id_valid = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hits, misses, stall, redirect, HLT, wrap, async reset.
// Inputs change 1 time unit after posedge; outputs are checked there too.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc2;
    logic        if_id_valid;
    logic        halted;

    int ntests = 0;
    int nfail  = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdy    (imem_rdy),
        .imem_data   (imem_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_instr (if_id_instr),
        .if_id_pc2   (if_id_pc2),
        .if_id_valid (if_id_valid),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rdy, input logic [15:0] data,
                       input logic stl, input logic rd,
                       input logic [15:0] rpc);
        imem_rdy    = rdy;
        imem_data   = data;
        stall       = stl;
        redirect    = rd;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic ifid(input string tag, input logic [15:0] ins,
                        input logic [15:0] pc2, input logic v,
                        input logic [15:0] addr);
        chk({tag, ".instr"}, if_id_instr, ins);
        chk({tag, ".pc2"},   if_id_pc2,   pc2);
        chk({tag, ".valid"}, 16'(if_id_valid), 16'(v));
        chk({tag, ".addr"},  imem_addr,   addr);
    endtask

    initial begin
        rst = 1'b0;
        imem_rdy = 1'b0; imem_data = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #12;
        ifid("reset", 16'h0000, 16'h0000, 1'b0, 16'h0000);
        chk("reset.req",    16'(imem_req), 16'd1);
        chk("reset.halted", 16'(halted),   16'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        cyc(1, 16'h1234, 0, 0, 0);
        ifid("hit0", 16'h1234, 16'h0002, 1'b1, 16'h0002);
        cyc(1, 16'h2345, 0, 0, 0);
        ifid("hit1", 16'h2345, 16'h0004, 1'b1, 16'h0004);
        cyc(1, 16'h3456, 0, 0, 0);
        ifid("hit2", 16'h3456, 16'h0006, 1'b1, 16'h0006);

        cyc(0, 16'h0000, 0, 1, 16'h0010);
        ifid("redir10", 16'h0000, 16'h0000, 1'b0, 16'h0010);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 16'hDEAD, 0, 0, 0);
            ifid($sformatf("miss%0d", i), 16'h0000, 16'h0000, 1'b0, 16'h0010);
            chk($sformatf("miss%0d.req", i), 16'(imem_req), 16'd1);
        end
        cyc(1, 16'h4567, 0, 0, 0);
        ifid("missdone", 16'h4567, 16'h0012, 1'b1, 16'h0012);

        cyc(1, 16'h5555, 1, 0, 0);
        ifid("stall0", 16'h4567, 16'h0012, 1'b1, 16'h0012);
        chk("stall0.req", 16'(imem_req), 16'd1);
        cyc(1, 16'h5555, 1, 0, 0);
        ifid("stall1", 16'h4567, 16'h0012, 1'b1, 16'h0012);
        cyc(1, 16'h5678, 0, 0, 0);
        ifid("unstall", 16'h5678, 16'h0014, 1'b1, 16'h0014);

        cyc(0, 16'h0000, 0, 0, 0);
        ifid("premiss", 16'h0000, 16'h0014, 1'b0, 16'h0014);
        cyc(1, 16'h9999, 0, 1, 16'h0100);
        ifid("flushmiss", 16'h0000, 16'h0000, 1'b0, 16'h0100);
        cyc(1, 16'h7777, 1, 1, 16'h0020);
        ifid("redirstall", 16'h0000, 16'h0000, 1'b0, 16'h0020);

        cyc(1, 16'hF000, 0, 0, 0);
        ifid("hlt", 16'hF000, 16'h0022, 1'b1, 16'h0020);
        chk("hlt.halted", 16'(halted),   16'd1);
        chk("hlt.req",    16'(imem_req), 16'd0);
        cyc(1, 16'h1111, 0, 0, 0);
        ifid("halted", 16'h0000, 16'h0022, 1'b0, 16'h0020);
        chk("halted.halted", 16'(halted), 16'd1);
        cyc(0, 16'h0000, 0, 1, 16'h0040);
        chk("unhalt.halted", 16'(halted),   16'd0);
        chk("unhalt.req",    16'(imem_req), 16'd1);
        chk("unhalt.addr",   imem_addr,     16'h0040);
        cyc(1, 16'h1111, 0, 0, 0);
        ifid("resume", 16'h1111, 16'h0042, 1'b1, 16'h0042);

        cyc(0, 16'h0000, 0, 1, 16'hFFFE);
        cyc(1, 16'h2222, 0, 0, 0);
        ifid("wrap", 16'h2222, 16'h0000, 1'b1, 16'h0000);
        cyc(1, 16'h3333, 0, 0, 0);
        ifid("postwrap", 16'h3333, 16'h0002, 1'b1, 16'h0002);

        cyc(0, 16'h0000, 0, 0, 0);
        ifid("rstmiss", 16'h0000, 16'h0002, 1'b0, 16'h0002);
        #2 rst = 1'b0;
        #1;
        ifid("asyncrst", 16'h0000, 16'h0000, 1'b0, 16'h0000);
        chk("asyncrst.req", 16'(imem_req), 16'd1);
        #1 rst = 1'b1;
        cyc(1, 16'h4444, 0, 0, 0);
        ifid("postrst", 16'h4444, 16'h0002, 1'b1, 16'h0002);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
